// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and load writeback requests, hazard queries and the
// register-file write port. The requester/register-file side is the master.
interface wb_arbiter_if #(
  parameter int WIDTH      = 64,
  parameter int BANK_WIDTH = 5
);
  logic                  alu_valid;
  logic [BANK_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;

  logic                  ld_valid;
  logic [BANK_WIDTH-1:0] ld_rd;
  logic [WIDTH-1:0]      ld_data;
  logic                  ld_ready;

  logic [BANK_WIDTH-1:0] q1;
  logic [BANK_WIDTH-1:0] q2;
  logic                  pend1;
  logic                  pend2;

  logic                  we3;
  logic [BANK_WIDTH-1:0] wa3;
  logic [WIDTH-1:0]      wd3;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q1, q2,
    input  alu_ready, ld_ready, pend1, pend2, we3, wa3, wd3
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, q1, q2,
    output alu_ready, ld_ready, pend1, pend2, we3, wa3, wd3
  );
endinterface

// File: rtl/wb_arbiter.sv
// Single-port register-file writeback arbiter: ALU writes win, loads wait in a
// small FIFO, older buffered loads are squashed by newer ALU writes (WAW).
module wb_arbiter #(
  parameter int WIDTH        = 64,
  parameter int BANK_WIDTH   = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

  logic [BANK_WIDTH-1:0] r_rd   [DEPTH];
  logic [WIDTH-1:0]      r_data [DEPTH];
  logic [DEPTH-1:0]      r_live;
  logic [DEPTH-1:0]      r_squash;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_starve;
  logic                  r_we3;
  logic [BANK_WIDTH-1:0] r_wa3;
  logic [WIDTH-1:0]      r_wd3;

  logic                  w_alu_ready;
  logic                  w_ld_ready;
  logic                  w_alu_wr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_issue;
  logic [DEPTH-1:0]      w_live_nxt;
  logic [DEPTH-1:0]      w_squash_nxt;
  logic                  w_pend1;
  logic                  w_pend2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // An ALU request to r0 is accepted but never writes; a load to r0 handshakes
  // but is never buffered. The head pops whenever the ALU does not take the port.
  always_comb begin
    w_alu_ready  = (r_starve != STARVE_C);
    w_ld_ready   = (r_count < DEPTH_C);
    w_alu_wr     = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
    w_push       = bus.ld_valid && w_ld_ready && (bus.ld_rd != '0);
    w_pop        = !w_alu_wr && (r_count != '0);
    w_head_issue = w_pop && !r_squash[r_rd_ptr];
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_live_nxt   = r_live;
    w_squash_nxt = r_squash;
    if (w_alu_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_live[i] && (r_rd[i] == bus.alu_rd)) w_squash_nxt[i] = 1'b1;
      end
    end
    if (w_pop) w_live_nxt[r_rd_ptr] = 1'b0;
    if (w_push) begin
      w_live_nxt[r_wr_ptr]   = 1'b1;
      w_squash_nxt[r_wr_ptr] = w_alu_wr && (bus.ld_rd == bus.alu_rd);
    end
  end

  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && !r_squash[i]) begin
        if ((bus.q1 != '0) && (r_rd[i] == bus.q1)) w_pend1 = 1'b1;
        if ((bus.q2 != '0) && (r_rd[i] == bus.q2)) w_pend2 = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live   <= '0;
      r_squash <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we3    <= 1'b0;
      r_wa3    <= '0;
      r_wd3    <= '0;
    end else begin
      r_live   <= w_live_nxt;
      r_squash <= w_squash_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop)
        r_starve <= '0;
      else if ((r_count != '0) && (r_starve != STARVE_C))
        r_starve <= r_starve + 1'b1;
      r_we3 <= w_alu_wr || w_head_issue;
      if (w_alu_wr) begin
        r_wa3 <= bus.alu_rd;
        r_wd3 <= bus.alu_data;
      end else if (w_head_issue) begin
        r_wa3 <= r_rd[r_rd_ptr];
        r_wd3 <= r_data[r_rd_ptr];
      end
    end
  end

  // NOTE: the payload array is deliberately not reset; the live bits alone
  // decide which entries are meaningful, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wr_ptr]   <= bus.ld_rd;
      r_data[r_wr_ptr] <= bus.ld_data;
    end
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.pend1     = w_pend1;
  assign bus.pend2     = w_pend2;
  assign bus.we3       = r_we3;
  assign bus.wa3       = r_wa3;
  assign bus.wd3       = r_wd3;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a queue-based reference model.
module tb_wb_arbiter;
  localparam int WIDTH        = 64;
  localparam int BANK_WIDTH   = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic reset_n;

  wb_arbiter_if #(.WIDTH(WIDTH), .BANK_WIDTH(BANK_WIDTH)) bus ();

  wb_arbiter #(
    .WIDTH(WIDTH), .BANK_WIDTH(BANK_WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BANK_WIDTH-1:0] rd;
    logic [WIDTH-1:0]      data;
    bit                    sq;
  } ent_t;

  ent_t                  mq[$];
  int                    m_starve = 0;
  bit                    exp_we   = 1'b0;
  logic [BANK_WIDTH-1:0] exp_wa   = '0;
  logic [WIDTH-1:0]      exp_wd   = '0;
  int                    checks   = 0;
  int                    errors   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(input logic [BANK_WIDTH-1:0] q);
    if (q == '0) return 1'b0;
    foreach (mq[i]) if (!mq[i].sq && (mq[i].rd == q)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: one write per cycle, ALU first, then the FIFO head.
  task automatic model_step();
    bit   alu_w;
    bit   push;
    bit   popped;
    int   n;
    ent_t e;
    n      = mq.size();
    alu_w  = bus.alu_valid && (m_starve != STARVE_LIMIT) && (bus.alu_rd != '0);
    push   = bus.ld_valid && (n < DEPTH) && (bus.ld_rd != '0);
    exp_we = 1'b0;
    popped = 1'b0;
    if (alu_w) begin
      exp_we = 1'b1;
      exp_wa = bus.alu_rd;
      exp_wd = bus.alu_data;
      foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].sq = 1'b1;
    end else if (n > 0) begin
      e      = mq.pop_front();
      popped = 1'b1;
      if (!e.sq) begin
        exp_we = 1'b1;
        exp_wa = e.rd;
        exp_wd = e.data;
      end
    end
    if (popped) m_starve = 0;
    else if ((n > 0) && (m_starve < STARVE_LIMIT)) m_starve++;
    if (push) begin
      e.rd   = bus.ld_rd;
      e.data = bus.ld_data;
      e.sq   = alu_w && (bus.ld_rd == bus.alu_rd);
      mq.push_back(e);
    end
  endtask

  // Called at posedge+1; checks combinational outputs, clocks once, checks the write port.
  task automatic tick();
    #1;
    check("alu_ready", 64'(bus.alu_ready), 64'(m_starve != STARVE_LIMIT));
    check("ld_ready",  64'(bus.ld_ready),  64'(mq.size() < DEPTH));
    check("pend1",     64'(bus.pend1),     64'(m_pend(bus.q1)));
    check("pend2",     64'(bus.pend2),     64'(m_pend(bus.q2)));
    model_step();
    @(posedge clk);
    #1;
    check("we3", 64'(bus.we3), 64'(exp_we));
    if (exp_we) begin
      check("wa3", 64'(bus.wa3), 64'(exp_wa));
      check("wd3", bus.wd3, exp_wd);
    end
  endtask

  task automatic drive(input bit av, input logic [BANK_WIDTH-1:0] ard, input logic [WIDTH-1:0] ad,
                       input bit lv, input logic [BANK_WIDTH-1:0] lrd, input logic [WIDTH-1:0] ldd);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldd;
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_we3",       64'(bus.we3),       64'd0);
    check("rst_wa3",       64'(bus.wa3),       64'd0);
    check("rst_wd3",       bus.wd3,            64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rst_ld_ready",  64'(bus.ld_ready),  64'd1);
    check("rst_pend1",     64'(bus.pend1),     64'd0);
    check("rst_pend2",     64'(bus.pend2),     64'd0);
    mq.delete();
    m_starve = 0;
    exp_we   = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_we3", 64'(bus.we3), 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    bus.q1 = '0;
    bus.q2 = '0;
    #3;
    check("por_we3",       64'(bus.we3),       64'd0);
    check("por_wa3",       64'(bus.wa3),       64'd0);
    check("por_wd3",       bus.wd3,            64'd0);
    check("por_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("por_ld_ready",  64'(bus.ld_ready),  64'd1);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU only, then ALU to r0
    drive(1'b1, 5'd5, 64'hAA, 1'b0, '0, '0);
    tick();
    check("alu5_we3", 64'(bus.we3), 64'd1);
    check("alu5_wa3", 64'(bus.wa3), 64'd5);
    check("alu5_wd3", bus.wd3,      64'hAA);
    drive(1'b1, 5'd0, 64'hBB, 1'b0, '0, '0);
    tick();
    check("alu0_we3", 64'(bus.we3), 64'd0);

    // two loads, no ALU traffic
    drive(1'b0, '0, '0, 1'b1, 5'd3, 64'h33);
    tick();
    check("ld3_push_we3", 64'(bus.we3), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 5'd4, 64'h44);
    tick();
    check("ld3_we3", 64'(bus.we3), 64'd1);
    check("ld3_wa3", 64'(bus.wa3), 64'd3);
    check("ld3_wd3", bus.wd3,      64'h33);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("ld4_we3",   64'(bus.we3),      64'd1);
    check("ld4_wa3",   64'(bus.wa3),      64'd4);
    check("ld4_wd3",   bus.wd3,           64'h44);
    check("ld4_ready", 64'(bus.ld_ready), 64'd1);
    tick();
    check("ld_idle_we3", 64'(bus.we3), 64'd0);

    // buffered load squashed by a newer ALU write to the same register
    drive(1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
    bus.q1 = 5'd7;
    tick();
    check("sq_pend_before", 64'(bus.pend1), 64'd1);
    drive(1'b1, 5'd7, 64'h11, 1'b0, '0, '0);
    tick();
    check("sq_alu_we3",    64'(bus.we3),   64'd1);
    check("sq_alu_wa3",    64'(bus.wa3),   64'd7);
    check("sq_alu_wd3",    bus.wd3,        64'h11);
    check("sq_pend_after", 64'(bus.pend1), 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("sq_pop_we3", 64'(bus.we3), 64'd0);
    bus.q1 = '0;

    // starvation: ALU held busy while a load waits
    drive(1'b0, '0, '0, 1'b1, 5'd12, 64'hC0);
    tick();
    check("st_ready0", 64'(bus.alu_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(20 + k), 64'(k), (k == 0), 5'd13, 64'hD0);
      tick();
      if (k == 0) check("st_full_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("st_alu_ready", 64'(bus.alu_ready), 64'(k != 3));
      check("st_we3",       64'(bus.we3),       64'd1);
      check("st_wa3",       64'(bus.wa3),       (k == 4) ? 64'd12 : 64'(20 + k));
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("st_drain_wa3", 64'(bus.wa3), 64'd13);
    tick();

    // same-cycle ALU and load to r9
    drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 64'h55);
    tick();
    check("same_we3", 64'(bus.we3), 64'd1);
    check("same_wa3", 64'(bus.wa3), 64'd9);
    check("same_wd3", bus.wd3,      64'h99);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    check("same_pop_we3", 64'(bus.we3), 64'd0);
    tick();
    check("same_idle_we3", 64'(bus.we3), 64'd0);

    // reset with two entries buffered
    drive(1'b0, '0, '0, 1'b1, 5'd3, 64'h03);
    tick();
    drive(1'b1, 5'd21, 64'h21, 1'b1, 5'd4, 64'h04);
    bus.q1 = 5'd3;
    tick();
    check("rb_we3",   64'(bus.we3),   64'd1);
    check("rb_pend1", 64'(bus.pend1), 64'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    async_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rb_after_we3", 64'(bus.we3), 64'd0);
    end
    bus.q1 = '0;

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 2000; n++) begin
      int alu_pct;
      alu_pct = ((n / 200) % 2 == 1) ? 90 : 40;
      drive($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
      bus.q1 = 5'($urandom_range(0, 7));
      bus.q2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) async_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
